mem_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline. Consumes the EXE/MEM pipeline register outputs and performs 32-bit data loads/stores against the board's external 16-bit SRAM as two half-word accesses.
- Raises `freeze` to stall all upstream pipeline registers while an access is in flight.
- Contains the MEM/WB pipeline register feeding write-back.

---
 rtl/mem_stage.sv | 118 +++++++++++
 tb/tb_mem_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MIPS MEM stage: 32-bit loads/stores as two half-word SRAM accesses, plus the MEM/WB register.
// Latency: 1 cycle for non-memory ops; a memory op holds freeze for its IDLE cycle plus 2*SRAM_WAIT cycles.
// Backpressure: freeze stalls every upstream register; MEM/WB takes bubbles until the access reaches DONE.
module mem_stage #(
    parameter int ADDR_BASE = 1024,
    parameter int SRAM_AW   = 18,
    parameter int SRAM_WAIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_en_in,
    input  logic               mem_r_en_in,
    input  logic               mem_w_en_in,
    input  logic [31:0]        pc_in,
    input  logic [31:0]        alu_result_in,
    input  logic [31:0]        st_val_in,
    input  logic [31:0]        dest_in,
    output logic               freeze,
    output logic               wb_en,
    output logic               mem_r_en,
    output logic [31:0]        pc,
    output logic [31:0]        alu_result,
    output logic [31:0]        mem_data,
    output logic [31:0]        dest,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [15:0]        sram_dq,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

    localparam int          CW   = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam logic [31:0] BASE = 32'(ADDR_BASE);

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic                last;
    logic                access;
    logic [31:0]         off;
    logic [SRAM_AW-1:0]  lo_addr, hi_addr;
    logic [15:0]         lo_buf, hi_buf;

    // Word-aligned half-word pair; anything beyond the SRAM simply wraps.
    assign off     = alu_result_in - BASE;
    assign lo_addr = SRAM_AW'((off >> 2) << 1);
    assign hi_addr = lo_addr + SRAM_AW'(1);

    assign access = (state == RD_LO) || (state == RD_HI) || (state == WR_LO) || (state == WR_HI);
    assign last   = (cnt == CW'(SRAM_WAIT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_r_en_in)      state_nxt = RD_LO;
                else if (mem_w_en_in) state_nxt = WR_LO;
            end
            RD_LO:   if (last) state_nxt = RD_HI;
            RD_HI:   if (last) state_nxt = DONE;
            WR_LO:   if (last) state_nxt = WR_HI;
            WR_HI:   if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (access && !last) ? cnt + CW'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lo_buf <= '0;
            hi_buf <= '0;
        end else begin
            if (state == RD_LO && last) lo_buf <= sram_dq;
            if (state == RD_HI && last) hi_buf <= sram_dq;
        end
    end

    // DONE is the one cycle of a memory op where the pipeline is allowed to advance.
    assign freeze = rst && (mem_r_en_in || mem_w_en_in) && (state != DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_en      <= 1'b0;
            mem_r_en   <= 1'b0;
            pc         <= '0;
            alu_result <= '0;
            mem_data   <= '0;
            dest       <= '0;
        end else if (freeze) begin
            wb_en    <= 1'b0;
            mem_r_en <= 1'b0;
        end else begin
            wb_en      <= wb_en_in;
            mem_r_en   <= mem_r_en_in;
            pc         <= pc_in;
            alu_result <= alu_result_in;
            dest       <= dest_in;
            if (state == DONE && mem_r_en_in) mem_data <= {hi_buf, lo_buf};
        end
    end

    assign sram_oe_n = !((state == RD_LO) || (state == RD_HI));
    assign sram_we_n = !((state == WR_LO) || (state == WR_HI));
    assign sram_addr = ((state == RD_HI) || (state == WR_HI)) ? hi_addr : lo_addr;
    assign sram_dq   = (state == WR_LO) ? st_val_in[15:0]  :
                       (state == WR_HI) ? st_val_in[31:16] : 16'bz;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a small behavioural SRAM on the tristate bus.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] pc_in, alu_result_in, st_val_in, dest_in;
    logic        freeze, wb_en, mem_r_en;
    logic [31:0] pc, alu_result, mem_data, dest;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n, sram_oe_n;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .wb_en_in     (wb_en_in),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .pc_in        (pc_in),
        .alu_result_in(alu_result_in),
        .st_val_in    (st_val_in),
        .dest_in      (dest_in),
        .freeze       (freeze),
        .wb_en        (wb_en),
        .mem_r_en     (mem_r_en),
        .pc           (pc),
        .alu_result   (alu_result),
        .mem_data     (mem_data),
        .dest         (dest),
        .sram_addr    (sram_addr),
        .sram_dq      (sram_dq),
        .sram_we_n    (sram_we_n),
        .sram_oe_n    (sram_oe_n)
    );

    // SRAM model: small array indexed by the low address bits, two fixed words at the top of memory.
    logic [15:0] sram_mem [8];
    logic [15:0] rd_word;

    always_comb begin
        case (sram_addr)
            18'h3FFFE: rd_word = 16'h1234;
            18'h3FFFF: rd_word = 16'h5678;
            default:   rd_word = sram_mem[sram_addr[2:0]];
        endcase
    end

    assign sram_dq = sram_oe_n ? 16'bz : rd_word;
    pullup (sram_dq);

    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr[2:0]] <= sram_dq;
    end

    localparam logic [31:0] FLOAT = 32'h0000_FFFF;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, " freeze"}, 32'(freeze), 32'd1);
        check({tag, " we_n"}, 32'(sram_we_n), 32'd0);
        check({tag, " oe_n"}, 32'(sram_oe_n), 32'd1);
        check({tag, " addr"}, 32'(sram_addr), addr);
        check({tag, " dq"}, 32'(sram_dq), data);
        check({tag, " wb_en bubble"}, 32'(wb_en), 32'd0);
    endtask

    task automatic check_rd(input string tag, input logic [31:0] addr);
        check({tag, " freeze"}, 32'(freeze), 32'd1);
        check({tag, " oe_n"}, 32'(sram_oe_n), 32'd0);
        check({tag, " we_n"}, 32'(sram_we_n), 32'd1);
        check({tag, " addr"}, 32'(sram_addr), addr);
        check({tag, " mem_r_en bubble"}, 32'(mem_r_en), 32'd0);
    endtask

    initial begin
        rst = 1'b0; wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b0;
        pc_in = 32'h1234; alu_result_in = 32'd1028; st_val_in = 32'h0; dest_in = 32'd3;

        // Reset with a load request pending.
        step(); step();
        check("rst freeze", 32'(freeze), 32'd0);
        check("rst wb_en", 32'(wb_en), 32'd0);
        check("rst mem_r_en", 32'(mem_r_en), 32'd0);
        check("rst pc", pc, 32'd0);
        check("rst alu", alu_result, 32'd0);
        check("rst mem_data", mem_data, 32'd0);
        check("rst dest", dest, 32'd0);
        check("rst we_n", 32'(sram_we_n), 32'd1);
        check("rst oe_n", 32'(sram_oe_n), 32'd1);
        check("rst dq float", 32'(sram_dq), FLOAT);

        // ALU pass-through.
        rst = 1'b1; mem_r_en_in = 1'b0;
        alu_result_in = 32'h55; dest_in = 32'd7; pc_in = 32'h100;
        #1 check("alu freeze pre", 32'(freeze), 32'd0);
        step();
        check("alu wb_en", 32'(wb_en), 32'd1);
        check("alu result", alu_result, 32'h55);
        check("alu dest", dest, 32'd7);
        check("alu pc", pc, 32'h100);
        check("alu mem_r_en", 32'(mem_r_en), 32'd0);
        check("alu freeze", 32'(freeze), 32'd0);

        // Store 0xDEADBEEF at byte 1028 -> half-words 2 and 3.
        wb_en_in = 1'b0; mem_w_en_in = 1'b1; alu_result_in = 32'd1028;
        st_val_in = 32'hDEAD_BEEF; pc_in = 32'h104; dest_in = 32'd0;
        #1 check("st idle freeze", 32'(freeze), 32'd1);
        check("st idle we_n", 32'(sram_we_n), 32'd1);
        step(); check_wr("st lo0", 32'd2, 32'hBEEF);
        step(); check_wr("st lo1", 32'd2, 32'hBEEF);
        step(); check_wr("st hi0", 32'd3, 32'hDEAD);
        step(); check_wr("st hi1", 32'd3, 32'hDEAD);
        step();
        check("st done freeze", 32'(freeze), 32'd0);
        check("st done we_n", 32'(sram_we_n), 32'd1);
        check("st done dq float", 32'(sram_dq), FLOAT);
        step();
        check("st wb pc", pc, 32'h104);
        check("st wb wb_en", 32'(wb_en), 32'd0);
        check("sram word2", 32'(sram_mem[2]), 32'hBEEF);
        check("sram word3", 32'(sram_mem[3]), 32'hDEAD);

        // Load the same word back.
        mem_w_en_in = 1'b0; mem_r_en_in = 1'b1; wb_en_in = 1'b1;
        pc_in = 32'h108; dest_in = 32'd9;
        #1 check("ld idle freeze", 32'(freeze), 32'd1);
        step(); check_rd("ld lo0", 32'd2);
        step(); check_rd("ld lo1", 32'd2);
        step(); check_rd("ld hi0", 32'd3);
        step(); check_rd("ld hi1", 32'd3);
        step();
        check("ld done freeze", 32'(freeze), 32'd0);
        check("ld done oe_n", 32'(sram_oe_n), 32'd1);
        check("ld done mem_data hold", mem_data, 32'd0);
        step();
        check("ld mem_r_en", 32'(mem_r_en), 32'd1);
        check("ld wb_en", 32'(wb_en), 32'd1);
        check("ld mem_data", mem_data, 32'hDEAD_BEEF);
        check("ld pc", pc, 32'h108);
        check("ld dest", dest, 32'd9);
        check("ld alu", alu_result, 32'd1028);

        // Back-to-back: read+write together at byte 1020 (wraps to the top of SRAM).
        mem_w_en_in = 1'b1; alu_result_in = 32'd1020; pc_in = 32'h10C; dest_in = 32'd10;
        #1 check("cf idle freeze", 32'(freeze), 32'd1);
        check("cf idle oe_n", 32'(sram_oe_n), 32'd1);
        step(); check_rd("cf lo0", 32'h3FFFE);
        step(); check_rd("cf lo1", 32'h3FFFE);
        step(); check_rd("cf hi0", 32'h3FFFF);
        step(); check_rd("cf hi1", 32'h3FFFF);
        step();
        check("cf done freeze", 32'(freeze), 32'd0);
        check("cf done we_n", 32'(sram_we_n), 32'd1);
        step();
        check("cf mem_data", mem_data, 32'h5678_1234);
        check("cf mem_r_en", 32'(mem_r_en), 32'd1);
        check("cf dest", dest, 32'd10);

        // Non-memory op leaves mem_data untouched.
        mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; wb_en_in = 1'b0; alu_result_in = 32'h77;
        step();
        check("nm mem_data hold", mem_data, 32'h5678_1234);
        check("nm alu", alu_result, 32'h77);
        check("nm mem_r_en", 32'(mem_r_en), 32'd0);

        // Reset in the middle of WR_HI, request held across it.
        mem_w_en_in = 1'b1; alu_result_in = 32'd1032; st_val_in = 32'hCAFE_F00D; pc_in = 32'h110;
        step(); check_wr("rs lo0", 32'd4, 32'hF00D);
        step(); check_wr("rs lo1", 32'd4, 32'hF00D);
        step(); check_wr("rs hi0", 32'd5, 32'hCAFE);
        rst = 1'b0;
        step();
        check("rs we_n", 32'(sram_we_n), 32'd1);
        check("rs dq float", 32'(sram_dq), FLOAT);
        check("rs freeze", 32'(freeze), 32'd0);
        check("rs mem_data", mem_data, 32'd0);
        check("rs alu", alu_result, 32'd0);
        rst = 1'b1;
        #1 check("rs idle freeze", 32'(freeze), 32'd1);
        check("rs idle we_n", 32'(sram_we_n), 32'd1);
        step(); check_wr("rs restart", 32'd4, 32'hF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
